// File: rtl/burst_sequencer.sv
// burst_sequencer: runs a burst of `burst_length` timer periods on a downstream
// period counter. A trigger rising edge starts the burst. Each period begins
// with a one-clock counter_start pulse and ends on a rising edge of
// counter_overflow. An optional idle gap of `gap_ticks` clocks separates
// consecutive periods. Abort stops the counter and ends the burst early.
//
// Optional feature: define BURST_SEQUENCER_RETRIGGER_EN so that a trigger edge
// during a burst restarts it from period zero. This path passes through a
// one-clock RESTART state that stops the counter before re-arming it.
module burst_sequencer #(
  parameter int burst_length = 4,
  parameter int gap_ticks    = 2,
  parameter int bitwidth     = $clog2(burst_length + 1),
  parameter int gap_bitwidth = (gap_ticks > 0) ? $clog2(gap_ticks + 1) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                trigger,
  input  logic                abort,
  input  logic                counter_overflow,
  output logic                counter_start,
  output logic                counter_stop,
  output logic                busy,
  output logic [bitwidth-1:0] burst_index,
  output logic                done,
  output logic                aborted
);

  generate
    if (burst_length < 1) begin : g_bad_burst_length
      $error("burst_sequencer: burst_length must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3
`ifdef BURST_SEQUENCER_RETRIGGER_EN
    ,
    ST_RESTART = 3'd4
`endif
  } state_e;

  // Compare constants, sized to the registers they are compared against.
  localparam logic [bitwidth:0]       burst_len_w = (bitwidth + 1)'(burst_length);
  localparam logic [gap_bitwidth-1:0] gap_last    =
    gap_bitwidth'((gap_ticks > 0) ? gap_ticks - 1 : 0);

  state_e                  state_q, state_d;
  logic                    trigger_prev_q, ovf_prev_q;
  logic [gap_bitwidth-1:0] gap_count_q, gap_count_d;
  logic [bitwidth-1:0]     burst_index_q, burst_index_d;
  logic                    start_q, start_d;
  logic                    stop_q, stop_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic                    trig_edge, ovf_edge;
  logic [bitwidth:0]       index_inc;

  assign trig_edge = trigger & ~trigger_prev_q;
  assign ovf_edge  = counter_overflow & ~ovf_prev_q;
  assign index_inc = {1'b0, burst_index_q} + {{bitwidth{1'b0}}, 1'b1};

  // State register, edge-detect history and registered outputs.
  // NOTE: every flop here is updated with <= so that all registers sample the
  // same pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      trigger_prev_q <= 1'b0;
      ovf_prev_q     <= 1'b0;
      gap_count_q    <= '0;
      burst_index_q  <= '0;
      start_q        <= 1'b0;
      stop_q         <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      trigger_prev_q <= trigger;
      ovf_prev_q     <= counter_overflow;
      gap_count_q    <= gap_count_d;
      burst_index_q  <= burst_index_d;
      start_q        <= start_d;
      stop_q         <= stop_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  // Next-state and next-output logic. Abort has top priority, then retrigger
  // (if built in), then the per-state sequencing.
  // NOTE: every signal gets a default first. Without that, any path that does
  // not assign a signal would infer a latch. The defaults also make the four
  // pulse outputs fall back to 0 on the next clock.
  always_comb begin
    state_d       = state_q;
    gap_count_d   = gap_count_q;
    burst_index_d = burst_index_q;
    start_d       = 1'b0;
    stop_d        = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    if ((state_q != ST_IDLE) && abort) begin
      // Abort wins over any coincident overflow or trigger edge; the index is
      // frozen so the caller can see how far the burst got.
      state_d   = ST_IDLE;
      busy_d    = 1'b0;
      stop_d    = 1'b1;
      aborted_d = 1'b1;
    end
`ifdef BURST_SEQUENCER_RETRIGGER_EN
    else if ((state_q != ST_IDLE) && trig_edge) begin
      // Restart from period zero; a coincident overflow edge is discarded.
      state_d       = ST_RESTART;
      stop_d        = 1'b1;
      burst_index_d = '0;
    end
`endif
    else begin
      case (state_q)
        ST_IDLE: begin
          if (trig_edge && !abort) begin
            state_d       = ST_ARM;
            burst_index_d = '0;
            busy_d        = 1'b1;
            start_d       = 1'b1;
          end
        end
        ST_ARM: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (ovf_edge) begin
            burst_index_d = index_inc[bitwidth-1:0];
            if (index_inc == burst_len_w) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else if (gap_ticks == 0) begin
              state_d = ST_ARM;
              start_d = 1'b1;
            end else begin
              state_d     = ST_GAP;
              gap_count_d = '0;
            end
          end
        end
        ST_GAP: begin
          gap_count_d = gap_count_q + gap_bitwidth'(1);
          if (gap_count_q == gap_last) begin
            state_d = ST_ARM;
            start_d = 1'b1;
          end
        end
`ifdef BURST_SEQUENCER_RETRIGGER_EN
        ST_RESTART: begin
          state_d = ST_ARM;
          start_d = 1'b1;
        end
`endif
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign counter_start = start_q;
  assign counter_stop  = stop_q;
  assign busy          = busy_q;
  assign burst_index   = burst_index_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: doc/burst_sequencer.md
# burst_sequencer

Sequences a fixed number of timer periods by driving the start/stop inputs of a downstream period counter and consuming its overflow flag. On a trigger it issues a start pulse and waits for the counter's overflow rising edge. It then optionally idles for a programmable gap and re-arms, until `burst_length` periods have elapsed. It sits directly upstream of a period counter, whose `start`, `stop` and `overflow` connect to this block's `counter_start`, `counter_stop` and `counter_overflow`.

## Interface
- `burst_length`, default 4: periods per burst; must be ≥1 (elaboration error otherwise).
- `gap_ticks`, default 2: idle clocks between an overflow edge and the next start; 0 allowed.
- `bitwidth`, default `$clog2(burst_length+1)`: width of `burst_index`.
- `gap_bitwidth`, default `$clog2(gap_ticks+1)`: width of the internal gap counter (minimum 1).

Ports:
- `clock`  in  1: single clock, all logic on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `trigger`  in  1: level input; a rising edge requests a burst.
- `abort`  in  1: level input; when high while busy, terminates the burst.
- `counter_overflow`  in  1: overflow flag from the downstream counter; held high until the counter restarts.
- `counter_start`  out  1: one-clock pulse requesting a fresh counter period.
- `counter_stop`  out  1: one-clock pulse halting the counter.
- `busy`  out  1: high while a burst is in progress.
- `burst_index`  out  `bitwidth`: number of periods completed in the current or last burst.
- `done`  out  1: one-clock pulse when the burst completes normally.
- `aborted`  out  1: one-clock pulse when a burst is aborted.

## Operation
- Input edge detection uses registered `trigger_prev` and `ovf_prev`, both reset to 0. `trig_edge = trigger & ~trigger_prev`; `ovf_edge = counter_overflow & ~ovf_prev`.
- States:
  - IDLE: waiting for a trigger.
  - ARM: `counter_start` is high. A state is entered through a transition that sets `counter_start<=1`; leaving it clears the signal.
  - WAIT: waiting for an overflow edge.
  - GAP: counting idle clocks.
  - RESTART: only exists with the macro.
- IDLE:
  - `trig_edge & ~abort`: go to ARM; `burst_index<=0`; `busy<=1`; `counter_start<=1`.
  - Trigger and abort in the same cycle: abort wins and the trigger is dropped.
- ARM: always goes to WAIT after one cycle.
- WAIT, on `ovf_edge`: `burst_index<=burst_index+1`, then exactly one of:
  - `burst_index+1==burst_length`: go to IDLE; `done<=1`; `busy<=0`.
  - `gap_ticks==0`: go to ARM.
  - Otherwise: go to GAP with `gap_count<=0`.
- GAP: `gap_count` increments each clock. When `gap_count==gap_ticks-1`, go to ARM.
- A level-held `counter_overflow` counts once, because only rising edges count.
- Abort while busy (any non-IDLE state):
  - Go to IDLE; `busy<=0`; `counter_stop<=1` and `aborted<=1` for one cycle.
  - `burst_index` is held at its value; `done` does not pulse.
  - Abort has priority over a simultaneous `ovf_edge` or `trig_edge`; `burst_index` is not incremented.
- Abort in IDLE has no effect and produces no pulses.
- `done`, `aborted`, `counter_start` and `counter_stop` are each high for exactly one clock.

## Timing
- Every output is registered.
- Reset values: `counter_start`, `counter_stop`, `busy`, `done`, `aborted` are 0; `burst_index` is 0; state is IDLE; `gap_count` is 0.
- Assertion of `reset_n` mid-burst clears everything immediately; no stop pulse is emitted.
- Trigger latency: `trig_edge` sampled at posedge k gives `counter_start` and `busy` high from posedge k.
- Re-arm latency: `ovf_edge` sampled at posedge t gives `counter_start` high from posedge t+`gap_ticks`.
- Completion: `done` rises at the posedge where the final `ovf_edge` is sampled. `busy` falls at the same edge.
- Back-to-back bursts: a new `trig_edge` is accepted at the posedge after `done`, with no dead cycle beyond IDLE.

## Configuration
- Macro: `BURST_SEQUENCER_RETRIGGER_EN`.
- Defined: `trig_edge` while busy (and `abort` low) restarts the burst.
  - Go to RESTART; `counter_stop<=1`; `burst_index<=0`; `busy` stays 1.
  - Next clock: go to ARM with `counter_start<=1`.
  - An `ovf_edge` coinciding with the retrigger is ignored.
- Undefined: `trig_edge` while busy is ignored, and the RESTART state is not compiled.

## Test plan
Defaults `burst_length=4`, `gap_ticks=2`. The bench counter model raises `counter_overflow` 8 clocks after `counter_start` and holds it until the next start.
- Reset: assert `reset_n=0` mid-burst → all outputs 0 within the same cycle; after release, `trigger` still starts a burst normally.
- Normal burst: single `trigger` rising edge → 4 `counter_start` pulses, each 2 clocks after the preceding overflow edge. Then one `done` pulse with `burst_index=4` and `busy` falling at the same edge.
- Abort: `abort` pulse after the 2nd overflow edge → `counter_stop=1` and `aborted=1` for one clock; `busy=0`; `burst_index=2`; no `done`.
- Abort and overflow edge in the same cycle during the 3rd period → `burst_index` stays 2; `aborted` pulses.
- Overflow held high 20 clocks with `gap_ticks=0` and `burst_length=1` → `done` pulses once; no extra `counter_start`.
- Trigger while busy after the 1st overflow edge:
  - Without the macro: ignored; `done` after 4 periods.
  - With `BURST_SEQUENCER_RETRIGGER_EN`: `counter_stop` pulse, then `counter_start` the next clock; `burst_index=0`; 4 further periods, then `done`.
